// File: rtl/fwd_hazard_sb.sv
// fwd_hazard_sb: operand forwarding selects, multi-cycle scoreboard and stall generation
module fwd_hazard_sb #(
  parameter int NUM_SRC = 3,
  parameter int NUM_STG = 2,
  parameter int MAX_LAT = 8,
  localparam int CW = $clog2(MAX_LAT + 1),
  localparam int FW = $clog2(NUM_STG + 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5*NUM_SRC-1:0]  src_idx,
  input  logic [NUM_SRC-1:0]    src_used,
  input  logic [4:0]            id_rd,
  input  logic                  id_rd_valid,
  input  logic [5*NUM_STG-1:0]  stg_rd,
  input  logic [NUM_STG-1:0]    stg_regwrite,
  input  logic [NUM_STG-1:0]    stg_ready,
  input  logic                  mc_issue_valid,
  input  logic [4:0]            mc_issue_rd,
  input  logic [CW-1:0]         mc_issue_lat,
  input  logic                  mc_wb_valid,
  input  logic [4:0]            mc_wb_rd,
  input  logic                  flush,
  output logic [FW*NUM_SRC-1:0] fwd_sel,
  output logic                  stall,
  output logic [31:0]           busy,
  output logic                  sb_timeout,
  output logic [31:0]           stall_cnt
);
  logic [31:1]   pending;
  logic [CW-1:0] cnt [1:31];
  logic [31:0]   bsy;
  logic          ohz, waw, to;
  assign bsy  = {pending, 1'b0};
  assign busy = bsy;
  // per-operand select (youngest ready stage, then multi-cycle bus) and operand hazards
  always_comb begin
    logic [4:0]    s;
    logic [FW-1:0] sel;
    logic          rh, lu, wh, act;
    fwd_sel = '0;
    ohz = 1'b0;
    s = '0;
    sel = '0;
    rh = 1'b0;
    lu = 1'b0;
    wh = 1'b0;
    act = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      s = src_idx[5*i +: 5];
      act = src_used[i] && s != 5'd0 && !rst;
      wh = mc_wb_valid && mc_wb_rd == s;
      sel = '0;
      rh = 1'b0;
      lu = 1'b0;
      for (int k = NUM_STG - 1; k >= 0; k--)
        if (stg_regwrite[k] && stg_rd[5*k +: 5] == s) begin
          lu = !stg_ready[k];
          if (stg_ready[k]) begin
            sel = FW'(k + 1);
            rh = 1'b1;
          end
        end
      if (!rh && wh) sel = FW'(NUM_STG + 1);
      fwd_sel[FW*i +: FW] = act ? sel : '0;
      ohz = ohz | (act && (lu || (bsy[s] && !wh)));
    end
  end
  assign waw   = id_rd_valid && id_rd != 5'd0 && bsy[id_rd] && !(mc_wb_valid && mc_wb_rd == id_rd);
  assign stall = (ohz | waw) & ~flush & ~rst;
  // a pending entry whose countdown is exhausted and that is not written back now has overrun
  always_comb begin
    to = 1'b0;
    for (int r = 1; r < 32; r++)
      to = to | (pending[r] && cnt[r] == '0 && !(mc_wb_valid && mc_wb_rd == 5'(r)));
  end
  // scoreboard entries (issue beats writeback), sticky overrun flag, saturating stall counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pending <= '0;
      for (int r = 1; r < 32; r++) cnt[r] <= '0;
      sb_timeout <= 1'b0;
      stall_cnt <= '0;
    end else begin
      for (int r = 1; r < 32; r++)
        if (mc_issue_valid && mc_issue_rd == 5'(r)) begin
          pending[r] <= 1'b1;
          cnt[r] <= mc_issue_lat;
        end else if (mc_wb_valid && mc_wb_rd == 5'(r))
          pending[r] <= 1'b0;
        else if (pending[r] && cnt[r] != '0)
          cnt[r] <= cnt[r] - 1'b1;
      if (to) sb_timeout <= 1'b1;
      if (stall && ~&stall_cnt) stall_cnt <= stall_cnt + 32'd1;
    end
endmodule

// File: tb/tb_fwd_hazard_sb.sv
// tb_fwd_hazard_sb: directed vectors with a queued scoreboard checked by a negedge monitor
module tb_fwd_hazard_sb;
  localparam int NS = 3, NG = 2, CW = 4, FW = 2;
  localparam int M_FS = 1, M_ST = 2, M_BZ = 4, M_TO = 8, M_SC = 16, ALL = 31;
  logic clk = 0, rst = 1;
  logic [5*NS-1:0] src_idx;
  logic [NS-1:0] src_used;
  logic [4:0] id_rd, mc_issue_rd, mc_wb_rd;
  logic id_rd_valid, mc_issue_valid, mc_wb_valid, flush;
  logic [5*NG-1:0] stg_rd;
  logic [NG-1:0] stg_regwrite, stg_ready;
  logic [CW-1:0] mc_issue_lat;
  logic [FW*NS-1:0] fwd_sel;
  logic stall, sb_timeout;
  logic [31:0] busy, stall_cnt;
  typedef struct {
    string nm;
    int m;
    logic [5:0] fs;
    logic st;
    logic [31:0] bz;
    logic to;
    logic [31:0] sc;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;

  fwd_hazard_sb #(.NUM_SRC(NS), .NUM_STG(NG), .MAX_LAT(8)) dut (
    .clk(clk), .rst(rst), .src_idx(src_idx), .src_used(src_used),
    .id_rd(id_rd), .id_rd_valid(id_rd_valid), .stg_rd(stg_rd),
    .stg_regwrite(stg_regwrite), .stg_ready(stg_ready),
    .mc_issue_valid(mc_issue_valid), .mc_issue_rd(mc_issue_rd), .mc_issue_lat(mc_issue_lat),
    .mc_wb_valid(mc_wb_valid), .mc_wb_rd(mc_wb_rd), .flush(flush),
    .fwd_sel(fwd_sel), .stall(stall), .busy(busy), .sb_timeout(sb_timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, f, act, ex);
    end
  endtask

  always @(negedge clk)
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      if ((e.m & M_FS) != 0) chk(e.nm, "fwd_sel", 32'(fwd_sel), 32'(e.fs));
      if ((e.m & M_ST) != 0) chk(e.nm, "stall", 32'(stall), 32'(e.st));
      if ((e.m & M_BZ) != 0) chk(e.nm, "busy", busy, e.bz);
      if ((e.m & M_TO) != 0) chk(e.nm, "sb_timeout", 32'(sb_timeout), 32'(e.to));
      if ((e.m & M_SC) != 0) chk(e.nm, "stall_cnt", stall_cnt, e.sc);
    end

  task automatic idle();
    src_idx = '0; src_used = '0; id_rd = '0; id_rd_valid = 0;
    stg_rd = '0; stg_regwrite = '0; stg_ready = '0;
    mc_issue_valid = 0; mc_issue_rd = '0; mc_issue_lat = '0;
    mc_wb_valid = 0; mc_wb_rd = '0; flush = 0;
  endtask

  task automatic src(input int i, input logic [4:0] r, input logic u);
    src_idx[5*i +: 5] = r;
    src_used[i] = u;
  endtask

  task automatic stg(input int k, input logic [4:0] r, input logic w, input logic y);
    stg_rd[5*k +: 5] = r;
    stg_regwrite[k] = w;
    stg_ready[k] = y;
  endtask

  task automatic iss(input logic [4:0] r, input logic [CW-1:0] l);
    mc_issue_valid = 1; mc_issue_rd = r; mc_issue_lat = l;
  endtask

  task automatic wb(input logic [4:0] r);
    mc_wb_valid = 1; mc_wb_rd = r;
  endtask

  task automatic push(input string nm, input int m, input logic [5:0] fs, input logic st,
                      input logic [31:0] bz, input logic to, input logic [31:0] sc);
    exp_t e;
    e.nm = nm; e.m = m; e.fs = fs; e.st = st; e.bz = bz; e.to = to; e.sc = sc;
    q.push_back(e);
  endtask

  task automatic step(input string nm, input int m, input logic [5:0] fs, input logic st,
                      input logic [31:0] bz, input logic to, input logic [31:0] sc);
    push(nm, m, fs, st, bz, to, sc);
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic pulse(input string nm);
    rst = 1;
    push(nm, ALL, 6'h0, 0, 32'h0, 0, 32'h0);
    #6 rst = 0;
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle();
    @(posedge clk);
    #1;
    src(0, 5, 1); stg(0, 5, 1, 1);
    step("rst_hold", ALL, 6'h0, 0, 32'h0, 0, 0);
    rst = 0;
    src(0, 5, 1); stg(0, 5, 1, 1); stg(1, 5, 1, 1);
    step("fwd_young", ALL, 6'h1, 0, 32'h0, 0, 0);
    src(0, 5, 1); stg(0, 5, 0, 1); stg(1, 5, 1, 1);
    step("fwd_old", ALL, 6'h2, 0, 32'h0, 0, 0);
    src(0, 0, 1); stg(0, 0, 1, 1); stg(1, 0, 1, 1);
    step("fwd_x0", ALL, 6'h0, 0, 32'h0, 0, 0);
    src(1, 7, 1); stg(0, 7, 1, 0); stg(1, 7, 1, 1); flush = 1;
    step("lu_flush", ALL & ~M_FS, 6'h0, 0, 32'h0, 0, 0);
    src(1, 7, 1); stg(0, 7, 1, 0); stg(1, 7, 1, 1);
    step("lu_stall", ALL & ~M_FS, 6'h0, 1, 32'h0, 0, 0);
    src(2, 7, 0); stg(0, 7, 1, 1);
    step("unused", ALL, 6'h0, 0, 32'h0, 0, 1);
    iss(9, 4);
    step("mc_issue", ALL, 6'h0, 0, 32'h0, 0, 1);
    for (int j = 0; j < 3; j++) begin
      src(0, 9, 1);
      step("mc_wait", ALL, 6'h0, 1, 32'h200, 0, 32'(1 + j));
    end
    src(0, 9, 1); wb(9);
    step("mc_fwd", ALL, 6'h3, 0, 32'h200, 0, 4);
    src(0, 9, 1);
    step("mc_clear", ALL, 6'h0, 0, 32'h0, 0, 4);
    iss(3, 5);
    step("waw_iss", ALL, 6'h0, 0, 32'h0, 0, 4);
    id_rd = 3; id_rd_valid = 1;
    step("waw_stall", ALL, 6'h0, 1, 32'h8, 0, 4);
    iss(3, 2); wb(3);
    step("iss_wb", ALL, 6'h0, 0, 32'h8, 0, 5);
    step("reload_c2", ALL, 6'h0, 0, 32'h8, 0, 5);
    step("reload_c1", ALL, 6'h0, 0, 32'h8, 0, 5);
    step("reload_c0", ALL, 6'h0, 0, 32'h8, 0, 5);
    iss(20, 8);
    step("waw_to", ALL, 6'h0, 0, 32'h8, 1, 5);
    iss(21, 8);
    step("iss2", ALL, 6'h0, 0, 32'h100008, 1, 5);
    for (int j = 0; j < 12; j++) begin
      src(0, 20, 1);
      step("sb_stall", ALL, 6'h0, 1, 32'h300008, 1, 32'(5 + j));
    end
    step("pre_rst", ALL, 6'h0, 0, 32'h300008, 1, 17);
    src(0, 20, 1); stg(0, 20, 1, 1); id_rd = 3; id_rd_valid = 1;
    pulse("rst_mid");
    iss(12, 1);
    step("ov_iss", ALL, 6'h0, 0, 32'h0, 0, 0);
    step("ov_c1", ALL, 6'h0, 0, 32'h1000, 0, 0);
    step("ov_c0", ALL, 6'h0, 0, 32'h1000, 0, 0);
    step("ov_set", ALL, 6'h0, 0, 32'h1000, 1, 0);
    wb(12);
    step("ov_wb", ALL, 6'h0, 0, 32'h1000, 1, 0);
    step("ov_sticky", ALL, 6'h0, 0, 32'h0, 1, 0);
    pulse("ov_rst");
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
